ponylink_tx_sched: RTL and testbench
====================================

PONYLINK_TX_SCHED -- requirements
Module: ponylink_tx_sched

Interface
REQ-001 Parameter RECVRESET, default 0: if 0, reset-sequence body word is 9'h1fe; if 1, it is 9'h1fd.
REQ-002 Parameter IDLE_SYM, default 9'h1bc (K28.5): fill and comma symbol.
REQ-003 Parameter SYNC_INTERVAL, default 64, legal range 1..255: maximum run of non-IDLE_SYM symbols.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sym_en  input  1  symbol strobe; the encoder consumes sym and disp in this cycle.
REQ-007 enc_dispout  input  1  encoder running-disparity output for the current sym/disp.
REQ-008 send_reset  input  1  request to transmit the link-reset sequence.
REQ-009 ctrl_sym  input  8  control code; sent as {1'b1, ctrl_sym}.
REQ-010 ctrl_valid / ctrl_ready  input / output  1  control-symbol handshake.
REQ-011 din  input  8  data byte; sent as {1'b0, din}.
REQ-012 din_valid / din_ready  input / output  1  data handshake.
REQ-013 sym  output  9  registered symbol presented to the encoder.
REQ-014 disp  output  1  registered running disparity presented to the encoder.
REQ-015 rst_busy  output  1  high while a reset sequence is pending or being sent.

Function
REQ-016 All state changes other than send_reset capture and reset occur only in cycles with sym_en=1; sym, disp and the sync counter hold otherwise.
REQ-017 In a cycle with sym_en=1: disp <= enc_dispout, and sym <= the next symbol chosen by REQ-018.
REQ-018 Selection priority: (1) reset sequence; (2) forced comma (sync_cnt==SYNC_INTERVAL); (3) control symbol (ctrl_valid); (4) data (din_valid); (5) IDLE_SYM.
REQ-019 Reset sequence: 14 symbols, in order 9'h1fc, 4x body word, then 9'h006 through 9'h00e ascending.
- Counter seq_idx runs 0..13; the sequence completes on the sym_en that loads index 13.
- The sequence is never interrupted or reordered by other requests.
REQ-020 send_reset is latched in any cycle (sym_en not required) as pending when no sequence is pending or active.
- send_reset during a pending or active sequence is ignored; no queuing and no restart.
REQ-021 rst_busy is high from the cycle after send_reset capture through the cycle after index 13 is loaded into sym.
REQ-022 ctrl_ready = sym_en & ctrl selected under REQ-018, computed combinationally with ctrl_valid gating only the selection; a control transfer occurs when ctrl_valid & ctrl_ready.
REQ-023 din_ready = sym_en & no reset sequence pending/active & no comma forced & !ctrl_valid; a data transfer occurs when din_valid & din_ready.
REQ-024 At most one of ctrl_ready and din_ready is high in any cycle; neither is high when sym_en=0.
REQ-025 sync_cnt (8 bit), on sym_en:
- cleared to 0 when the loaded symbol equals IDLE_SYM;
- otherwise incremented, saturating at SYNC_INTERVAL.
REQ-026 A forced comma loads IDLE_SYM, which clears sync_cnt, so the next symbol is selected normally.
REQ-027 Reset-sequence symbols count toward sync_cnt; a forced comma is deferred until the sequence completes, then taken before ctrl or data.
REQ-028 Simultaneous send_reset and sym_en with sequence idle: the symbol loaded in that cycle is 9'h1fc.

Reset
REQ-029 On reset:
- sym=IDLE_SYM, disp=0, sync_cnt=0;
- no sequence pending, rst_busy=0, seq_idx=0.
REQ-030 Reset asserted mid-sequence abandons it; after deassertion, transmission resumes with normal selection and no partial sequence.
REQ-031 ctrl_ready and din_ready are 0 while reset is high.

Verification
REQ-032 Idle: no requests, sym_en every 4th clk for 200 symbols -> sym constant 9'h1bc; disp tracks enc_dispout delayed one strobe.
REQ-033 Streaming: din_valid held, SYNC_INTERVAL=4 -> sym pattern 4 data words, 9'h1bc, repeating; din_ready low exactly on comma strobes.
REQ-034 Reset sequence: send_reset pulse with RECVRESET=1 and din_valid held:
- sym sequence 1fc, 1fd x4, 006..00e;
- din_ready low throughout; rst_busy spans exactly 14 strobes.
REQ-035 Arbitration: ctrl_valid and din_valid both high for 3 strobes -> 3 symbols {1'b1, ctrl_sym} sent and no data accepted; data accepted on the first strobe after ctrl_valid drops.
REQ-036 Reset mid-sequence: reset after the 7th sequence symbol, then released -> sym=9'h1bc, rst_busy=0; a new send_reset restarts at 9'h1fc.
REQ-037 Corner cases: send_reset repeated during an active sequence -> exactly one 14-symbol sequence; send_reset while sym_en=0 -> captured, first symbol appears on the next strobe.

Source files
------------

// File: rtl/ponylink_tx_sched.sv
// Symbol scheduler in front of an 8b/10b encoder: arbitrates the link-reset sequence,
// forced commas, control symbols and data, and registers the symbol/disparity pair.
module ponylink_tx_sched #(
    parameter bit          RECVRESET     = 1'b0,
    parameter logic [8:0]  IDLE_SYM      = 9'h1bc,
    parameter int unsigned SYNC_INTERVAL = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sym_en,
    input  logic       enc_dispout,
    input  logic       send_reset,
    input  logic [7:0] ctrl_sym,
    input  logic       ctrl_valid,
    output logic       ctrl_ready,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [8:0] sym,
    output logic       disp,
    output logic       rst_busy
);

    localparam logic [8:0] SEQ_HEAD = 9'h1fc;
    localparam logic [8:0] SEQ_BODY = RECVRESET ? 9'h1fd : 9'h1fe;
    localparam logic [3:0] SEQ_LAST = 4'd13;
    localparam logic [7:0] SYNC_MAX = 8'(SYNC_INTERVAL);

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_PENDING,
        SEQ_ACTIVE
    } seq_state_t;

    seq_state_t seq_state;
    logic [3:0] seq_idx;
    logic [7:0] sync_cnt;

    logic       seq_busy;
    logic       start_now;
    logic       seq_sel;
    logic       comma_force;
    logic       ctrl_sel;
    logic       data_sel;
    logic [8:0] seq_word;
    logic [8:0] next_sym;

    // A request arriving while the sequence is idle takes effect in the same cycle,
    // so a coincident strobe already loads the sequence head.
    always_comb begin
        seq_busy    = (seq_state != SEQ_IDLE);
        start_now   = send_reset && !seq_busy;
        seq_sel     = seq_busy || start_now;
        comma_force = (sync_cnt == SYNC_MAX);
        ctrl_sel    = !seq_sel && !comma_force && ctrl_valid;
        data_sel    = !seq_sel && !comma_force && !ctrl_valid && din_valid;
        ctrl_ready  = sym_en && !reset && ctrl_sel;
        din_ready   = sym_en && !reset && !seq_sel && !comma_force && !ctrl_valid;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        seq_word = SEQ_HEAD;
        case (seq_idx)
            4'd0:                      seq_word = SEQ_HEAD;
            4'd1, 4'd2, 4'd3, 4'd4:    seq_word = SEQ_BODY;
            default:                   seq_word = 9'd1 + {5'd0, seq_idx};
        endcase
    end

    always_comb begin
        next_sym = IDLE_SYM;
        if (seq_sel)
            next_sym = seq_word;
        else if (comma_force)
            next_sym = IDLE_SYM;
        else if (ctrl_sel)
            next_sym = {1'b1, ctrl_sym};
        else if (data_sel)
            next_sym = {1'b0, din};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym       <= IDLE_SYM;
            disp      <= 1'b0;
            sync_cnt  <= 8'd0;
            seq_state <= SEQ_IDLE;
            seq_idx   <= 4'd0;
            rst_busy  <= 1'b0;
        end else begin
            // Stays high for one cycle past the load of the final sequence word.
            rst_busy <= seq_sel;

            if (sym_en) begin
                sym  <= next_sym;
                disp <= enc_dispout;

                if (next_sym == IDLE_SYM)
                    sync_cnt <= 8'd0;
                else if (!comma_force)
                    sync_cnt <= sync_cnt + 8'd1;

                if (seq_sel) begin
                    if (seq_idx == SEQ_LAST) begin
                        seq_idx   <= 4'd0;
                        seq_state <= SEQ_IDLE;
                    end else begin
                        seq_idx   <= seq_idx + 4'd1;
                        seq_state <= SEQ_ACTIVE;
                    end
                end
            end else if (start_now) begin
                seq_state <= SEQ_PENDING;
            end
        end
    end

endmodule

// File: tb/tb_ponylink_tx_sched.sv
// Directed bench for ponylink_tx_sched: one instance with RECVRESET=1, SYNC_INTERVAL=4,
// plus a default-parameter instance on the same inputs for the default reset body word.
module tb_ponylink_tx_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       sym_en;
    logic       enc_dispout;
    logic       send_reset;
    logic [7:0] ctrl_sym;
    logic       ctrl_valid;
    logic [7:0] din;
    logic       din_valid;

    logic       ctrl_ready, din_ready, disp, rst_busy;
    logic [8:0] sym;
    logic       ctrl_ready_def, din_ready_def, disp_def, rst_busy_def;
    logic [8:0] sym_def;

    int n_checks = 0;
    int n_fail   = 0;

    logic       obs_cr, obs_dr, obs_rb_pre, obs_rb_post, obs_disp;
    logic [8:0] obs_sym, obs_sym_def;
    logic [7:0] cur;

    localparam logic [8:0] IDLE = 9'h1bc;
    logic [8:0] seq_exp     [14] = '{9'h1fc, 9'h1fd, 9'h1fd, 9'h1fd, 9'h1fd, 9'h006, 9'h007,
                                     9'h008, 9'h009, 9'h00a, 9'h00b, 9'h00c, 9'h00d, 9'h00e};
    logic [8:0] seq_exp_def [14] = '{9'h1fc, 9'h1fe, 9'h1fe, 9'h1fe, 9'h1fe, 9'h006, 9'h007,
                                     9'h008, 9'h009, 9'h00a, 9'h00b, 9'h00c, 9'h00d, 9'h00e};

    always #5 clk = ~clk;

    ponylink_tx_sched #(.RECVRESET(1'b1), .IDLE_SYM(9'h1bc), .SYNC_INTERVAL(4)) dut (
        .clk(clk), .reset(reset), .sym_en(sym_en), .enc_dispout(enc_dispout),
        .send_reset(send_reset), .ctrl_sym(ctrl_sym), .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sym(sym), .disp(disp), .rst_busy(rst_busy)
    );

    ponylink_tx_sched dut_def (
        .clk(clk), .reset(reset), .sym_en(sym_en), .enc_dispout(enc_dispout),
        .send_reset(send_reset), .ctrl_sym(ctrl_sym), .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready_def), .din(din), .din_valid(din_valid), .din_ready(din_ready_def),
        .sym(sym_def), .disp(disp_def), .rst_busy(rst_busy_def)
    );

    // Called just after a falling edge: one strobe, then gap-1 idle clocks.
    task automatic strobe(input int gap);
        sym_en = 1'b1;
        #1;
        obs_cr     = ctrl_ready;
        obs_dr     = din_ready;
        obs_rb_pre = rst_busy;
        @(negedge clk);
        sym_en      = 1'b0;
        obs_sym     = sym;
        obs_disp    = disp;
        obs_rb_post = rst_busy;
        obs_sym_def = sym_def;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; sym_en = 1'b0; enc_dispout = 1'b0; send_reset = 1'b0;
        ctrl_sym = 8'h00; ctrl_valid = 1'b0; din = 8'h00; din_valid = 1'b0;
        repeat (2) @(negedge clk);
        sym_en = 1'b1; send_reset = 1'b1; ctrl_valid = 1'b1; din_valid = 1'b1; enc_dispout = 1'b1;
        #1;
        n_checks++; if (ctrl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_ready got %b want 0", ctrl_ready); end
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready got %b want 0", din_ready); end
        n_checks++; if (din_ready_def !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready_def got %b want 0", din_ready_def); end
        @(negedge clk);
        n_checks++; if (sym !== IDLE) begin n_fail++; $display("FAIL reset_sym got %h want %h", sym, IDLE); end
        n_checks++; if (disp !== 1'b0) begin n_fail++; $display("FAIL reset_disp got %b want 0", disp); end
        n_checks++; if (rst_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rst_busy got %b want 0", rst_busy); end
        n_checks++; if (sym_def !== IDLE) begin n_fail++; $display("FAIL reset_sym_def got %h want %h", sym_def, IDLE); end
        sym_en = 1'b0; send_reset = 1'b0; ctrl_valid = 1'b0; din_valid = 1'b0; enc_dispout = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (rst_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got %b want 0", rst_busy); end
    endtask

    task automatic test_idle;
        logic exp_d;
        for (int i = 0; i < 200; i++) begin
            exp_d = 1'($urandom_range(0, 1));
            enc_dispout = exp_d;
            strobe(1);
            enc_dispout = ~exp_d;
            repeat (3) @(negedge clk);
            n_checks++; if (obs_sym !== IDLE) begin n_fail++; $display("FAIL idle_sym[%0d] got %h want %h", i, obs_sym, IDLE); end
            n_checks++; if (obs_disp !== exp_d) begin n_fail++; $display("FAIL idle_disp[%0d] got %b want %b", i, obs_disp, exp_d); end
            n_checks++; if (disp !== exp_d) begin n_fail++; $display("FAIL idle_disp_hold[%0d] got %b want %b", i, disp, exp_d); end
            n_checks++; if (obs_sym_def !== IDLE) begin n_fail++; $display("FAIL idle_sym_def[%0d] got %h want %h", i, obs_sym_def, IDLE); end
            n_checks++; if (obs_dr !== 1'b1) begin n_fail++; $display("FAIL idle_din_ready[%0d] got %b want 1", i, obs_dr); end
        end
    endtask

    task automatic test_stream;
        cur = 8'h10; din = cur; din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            strobe(2);
            n_checks++; if (obs_cr !== 1'b0) begin n_fail++; $display("FAIL stream_ctrl_ready[%0d] got %b want 0", i, obs_cr); end
            if (i % 5 == 4) begin
                n_checks++; if (obs_dr !== 1'b0) begin n_fail++; $display("FAIL stream_comma_ready[%0d] got %b want 0", i, obs_dr); end
                n_checks++; if (obs_sym !== IDLE) begin n_fail++; $display("FAIL stream_comma_sym[%0d] got %h want %h", i, obs_sym, IDLE); end
            end else begin
                n_checks++; if (obs_dr !== 1'b1) begin n_fail++; $display("FAIL stream_din_ready[%0d] got %b want 1", i, obs_dr); end
                n_checks++; if (obs_sym !== {1'b0, cur}) begin n_fail++; $display("FAIL stream_data_sym[%0d] got %h want %h", i, obs_sym, {1'b0, cur}); end
                cur = cur + 8'd1;
                din = cur;
            end
        end
    endtask

    task automatic test_reset_seq;
        send_reset = 1'b1;
        @(negedge clk);
        send_reset = 1'b0;
        n_checks++; if (rst_busy !== 1'b1) begin n_fail++; $display("FAIL seq_capture_busy got %b want 1", rst_busy); end
        n_checks++; if (sym !== IDLE) begin n_fail++; $display("FAIL seq_no_strobe_sym got %h want %h", sym, IDLE); end
        for (int i = 0; i < 14; i++) begin
            strobe(4);
            n_checks++; if (obs_dr !== 1'b0) begin n_fail++; $display("FAIL seq_din_ready[%0d] got %b want 0", i, obs_dr); end
            n_checks++; if (obs_rb_pre !== 1'b1) begin n_fail++; $display("FAIL seq_busy[%0d] got %b want 1", i, obs_rb_pre); end
            n_checks++; if (obs_sym !== seq_exp[i]) begin n_fail++; $display("FAIL seq_sym[%0d] got %h want %h", i, obs_sym, seq_exp[i]); end
            n_checks++; if (obs_sym_def !== seq_exp_def[i]) begin n_fail++; $display("FAIL seq_sym_def[%0d] got %h want %h", i, obs_sym_def, seq_exp_def[i]); end
        end
        n_checks++; if (obs_rb_post !== 1'b1) begin n_fail++; $display("FAIL seq_busy_after_last got %b want 1", obs_rb_post); end
        strobe(4);
        n_checks++; if (obs_rb_pre !== 1'b0) begin n_fail++; $display("FAIL seq_busy_end got %b want 0", obs_rb_pre); end
        n_checks++; if (obs_dr !== 1'b0) begin n_fail++; $display("FAIL seq_deferred_comma_ready got %b want 0", obs_dr); end
        n_checks++; if (obs_sym !== IDLE) begin n_fail++; $display("FAIL seq_deferred_comma_sym got %h want %h", obs_sym, IDLE); end
        strobe(4);
        n_checks++; if (obs_dr !== 1'b1) begin n_fail++; $display("FAIL seq_resume_ready got %b want 1", obs_dr); end
        n_checks++; if (obs_sym !== {1'b0, cur}) begin n_fail++; $display("FAIL seq_resume_sym got %h want %h", obs_sym, {1'b0, cur}); end
        cur = cur + 8'd1; din = cur;
    endtask

    task automatic test_arbitration;
        din_valid = 1'b0; ctrl_valid = 1'b0;
        strobe(2);
        n_checks++; if (obs_sym !== IDLE) begin n_fail++; $display("FAIL arb_idle_sym got %h want %h", obs_sym, IDLE); end
        ctrl_valid = 1'b1; din_valid = 1'b1; ctrl_sym = 8'h55;
        #1;
        n_checks++; if (ctrl_ready !== 1'b0) begin n_fail++; $display("FAIL arb_no_strobe_ctrl got %b want 0", ctrl_ready); end
        n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL arb_no_strobe_din got %b want 0", din_ready); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ctrl_sym = 8'h55 + 8'(i);
            strobe(2);
            n_checks++; if (obs_cr !== 1'b1) begin n_fail++; $display("FAIL arb_ctrl_ready[%0d] got %b want 1", i, obs_cr); end
            n_checks++; if (obs_dr !== 1'b0) begin n_fail++; $display("FAIL arb_din_ready[%0d] got %b want 0", i, obs_dr); end
            n_checks++; if (obs_sym !== {1'b1, 8'h55 + 8'(i)}) begin n_fail++; $display("FAIL arb_ctrl_sym[%0d] got %h want %h", i, obs_sym, {1'b1, 8'h55 + 8'(i)}); end
        end
        ctrl_valid = 1'b0;
        strobe(2);
        n_checks++; if (obs_cr !== 1'b0) begin n_fail++; $display("FAIL arb_after_ctrl_ready got %b want 0", obs_cr); end
        n_checks++; if (obs_dr !== 1'b1) begin n_fail++; $display("FAIL arb_after_din_ready got %b want 1", obs_dr); end
        n_checks++; if (obs_sym !== {1'b0, cur}) begin n_fail++; $display("FAIL arb_after_sym got %h want %h", obs_sym, {1'b0, cur}); end
        cur = cur + 8'd1; din = cur;
        ctrl_valid = 1'b1; ctrl_sym = 8'h3c;
        strobe(2);
        n_checks++; if (obs_cr !== 1'b0) begin n_fail++; $display("FAIL arb_comma_ctrl_ready got %b want 0", obs_cr); end
        n_checks++; if (obs_sym !== IDLE) begin n_fail++; $display("FAIL arb_comma_sym got %h want %h", obs_sym, IDLE); end
        strobe(2);
        n_checks++; if (obs_cr !== 1'b1) begin n_fail++; $display("FAIL arb_post_comma_ready got %b want 1", obs_cr); end
        n_checks++; if (obs_sym !== 9'h13c) begin n_fail++; $display("FAIL arb_post_comma_sym got %h want 13c", obs_sym); end
        ctrl_valid = 1'b0; din_valid = 1'b0;
    endtask

    task automatic test_reset_mid_seq;
        send_reset = 1'b1;
        @(negedge clk);
        send_reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            strobe(2);
            n_checks++; if (obs_sym !== seq_exp[i]) begin n_fail++; $display("FAIL mid_seq_sym[%0d] got %h want %h", i, obs_sym, seq_exp[i]); end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++; if (sym !== IDLE) begin n_fail++; $display("FAIL mid_reset_sym got %h want %h", sym, IDLE); end
        n_checks++; if (rst_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b want 0", rst_busy); end
        strobe(2);
        n_checks++; if (obs_rb_pre !== 1'b0) begin n_fail++; $display("FAIL mid_after_busy got %b want 0", obs_rb_pre); end
        n_checks++; if (obs_dr !== 1'b1) begin n_fail++; $display("FAIL mid_after_din_ready got %b want 1", obs_dr); end
        n_checks++; if (obs_sym !== IDLE) begin n_fail++; $display("FAIL mid_after_sym got %h want %h", obs_sym, IDLE); end
    endtask

    task automatic test_repeat_send_reset;
        din_valid = 1'b1; din = cur;
        send_reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 13) send_reset = 1'b0;
            strobe(2);
            if (i == 0) begin
                n_checks++; if (obs_dr !== 1'b0) begin n_fail++; $display("FAIL rep_same_cycle_ready got %b want 0", obs_dr); end
            end
            n_checks++; if (obs_sym !== seq_exp[i]) begin n_fail++; $display("FAIL rep_seq_sym[%0d] got %h want %h", i, obs_sym, seq_exp[i]); end
        end
        strobe(2);
        n_checks++; if (obs_rb_pre !== 1'b0) begin n_fail++; $display("FAIL rep_busy_end got %b want 0", obs_rb_pre); end
        n_checks++; if (obs_sym !== IDLE) begin n_fail++; $display("FAIL rep_comma_sym got %h want %h", obs_sym, IDLE); end
        strobe(2);
        n_checks++; if (obs_dr !== 1'b1) begin n_fail++; $display("FAIL rep_resume_ready got %b want 1", obs_dr); end
        n_checks++; if (obs_sym !== {1'b0, cur}) begin n_fail++; $display("FAIL rep_resume_sym got %h want %h", obs_sym, {1'b0, cur}); end
        din_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_idle;
        test_stream;
        test_reset_seq;
        test_arbitration;
        test_reset_mid_seq;
        test_repeat_send_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
